cdb_arbiter: RTL and testbench

//  Multi-source Common Data Bus for the Tomasulo core. N functional units

---
 rtl/cdb_arbiter.sv | 94 +++++++++
 tb/tb_cdb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one requesting functional unit per cycle
// (round-robin or fixed priority) and registers its result and tag onto the bus.
module cdb_arbiter #(
    parameter int N_SRC    = 4,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int ARB_MODE = 0,
    localparam int ID_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*DATA_W-1:0] in_data,
    input  logic [N_SRC*TAG_W-1:0]  in_RS_Name,
    output logic [N_SRC-1:0]        grant,
    output logic [DATA_W-1:0]       out,
    output logic [TAG_W-1:0]        RS_Name,
    output logic [ID_W-1:0]         src_id,
    output logic                    writeCDB
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SRC - 1);

    // Handshake: req[i] acts as valid and grant[i] as ready. A source holds
    // req, data and tag stable until it sees grant[i]=1 in the same cycle;
    // the transfer happens on that clock edge and the source may then drop
    // req or present its next result on the following cycle.

    logic [DATA_W-1:0] data_a [N_SRC];
    logic [TAG_W-1:0]  tag_a  [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign data_a[i] = in_data[i*DATA_W +: DATA_W];
        assign tag_a[i]  = in_RS_Name[i*TAG_W +: TAG_W];
    end

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] start_idx;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] win_idx;
    logic [ID_W-1:0] next_ptr;
    logic            found;
    logic            grant_any;

    assign start_idx = (ARB_MODE == 1) ? '0 : rr_ptr;

    // Walk N_SRC positions from the start index, wrapping by compare so that
    // non-power-of-two source counts never index past the last source.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = start_idx;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + ID_W'(1);
        end
    end

    assign grant_any = found && !reset && !flush;
    assign next_ptr  = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);

    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            writeCDB <= 1'b0;
            out      <= '0;
            RS_Name  <= '0;
            src_id   <= '0;
            rr_ptr   <= '0;
        end else if (grant_any) begin
            writeCDB <= 1'b1;
            out      <= data_a[win_idx];
            RS_Name  <= tag_a[win_idx];
            src_id   <= win_idx;
            if (ARB_MODE == 0) begin
                rr_ptr <= next_ptr;
            end
        end else begin
            // Idle or flushed: bus goes invalid, payload and pointer hold.
            writeCDB <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: one round-robin and one fixed-priority
// instance, each fed by its own behavioural sources, checked against a model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int IW = 2;
    localparam int EW = 1 + DW + TW + IW;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    logic [N-1:0]    req_rr, req_fp, grant_rr, grant_fp;
    logic [N*DW-1:0] data_rr, data_fp;
    logic [N*TW-1:0] tag_rr, tag_fp;
    logic [DW-1:0]   out_rr, out_fp;
    logic [TW-1:0]   rs_rr, rs_fp;
    logic [IW-1:0]   id_rr, id_fp;
    logic            wcdb_rr, wcdb_fp;

    always #5 clock = ~clock;

    cdb_arbiter #(.N_SRC(N), .DATA_W(DW), .TAG_W(TW), .ARB_MODE(0)) dut_rr (
        .clock(clock), .reset(reset), .flush(flush), .req(req_rr),
        .in_data(data_rr), .in_RS_Name(tag_rr), .grant(grant_rr),
        .out(out_rr), .RS_Name(rs_rr), .src_id(id_rr), .writeCDB(wcdb_rr)
    );

    cdb_arbiter #(.N_SRC(N), .DATA_W(DW), .TAG_W(TW), .ARB_MODE(1)) dut_fp (
        .clock(clock), .reset(reset), .flush(flush), .req(req_fp),
        .in_data(data_fp), .in_RS_Name(tag_fp), .grant(grant_fp),
        .out(out_fp), .RS_Name(rs_fp), .src_id(id_fp), .writeCDB(wcdb_fp)
    );

    // Scoreboard: expected bus word {writeCDB, out, RS_Name, src_id}.
    logic [EW-1:0] exp_rr[$];
    logic [EW-1:0] exp_fp[$];

    int total = 0;
    int bad   = 0;
    int policy;                 // 0: hold and reload, 1: drop after grant, 2: random
    int            mptr [2];
    logic [DW-1:0] mout [2];
    logic [TW-1:0] mtag [2];
    logic [IW-1:0] mid  [2];
    logic [N-1:0]  last_g [2];
    int            wait_cnt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input int start);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic set_src(input int m, input int i, input logic r, input logic [DW-1:0] d,
                           input logic [TW-1:0] t);
        if (m == 0) begin
            req_rr[i] = r; data_rr[i*DW +: DW] = d; tag_rr[i*TW +: TW] = t;
        end else begin
            req_fp[i] = r; data_fp[i*DW +: DW] = d; tag_fp[i*TW +: TW] = t;
        end
    endtask

    task automatic eval_inst(input int m);
        logic [N-1:0]    r, g, eg;
        logic [N*DW-1:0] d;
        logic [N*TW-1:0] t;
        logic [EW-1:0]   got, e;
        logic            have;
        int              w;
        have = 1'b0;
        e    = '0;
        if (m == 0) begin
            r = req_rr; g = grant_rr; d = data_rr; t = tag_rr;
            got = {wcdb_rr, out_rr, rs_rr, id_rr};
            if (exp_rr.size() > 0) begin e = exp_rr.pop_front(); have = 1'b1; end
        end else begin
            r = req_fp; g = grant_fp; d = data_fp; t = tag_fp;
            got = {wcdb_fp, out_fp, rs_fp, id_fp};
            if (exp_fp.size() > 0) begin e = exp_fp.pop_front(); have = 1'b1; end
        end
        if (have) check(m == 0 ? "bus_rr" : "bus_fp", 32'(got), 32'(e));

        eg = (reset || flush) ? '0 : model_grant(r, (m == 1) ? 0 : mptr[m]);
        check(m == 0 ? "grant_rr" : "grant_fp", 32'(g), 32'(eg));
        check(m == 0 ? "gnt_ok_rr" : "gnt_ok_fp", 32'($onehot0(g) && ((g & ~r) == '0)), 32'd1);

        if (reset) begin
            mptr[m] = 0; mout[m] = '0; mtag[m] = '0; mid[m] = '0;
            e = {1'b0, {DW{1'b0}}, {TW{1'b0}}, {IW{1'b0}}};
        end else if (eg != '0) begin
            w = $clog2(eg);
            mout[m] = d[w*DW +: DW];
            mtag[m] = t[w*TW +: TW];
            mid[m]  = IW'(w);
            if (m == 0) mptr[m] = (w + 1) % N;
            e = {1'b1, mout[m], mtag[m], mid[m]};
        end else begin
            e = {1'b0, mout[m], mtag[m], mid[m]};
        end
        if (m == 0) exp_rr.push_back(e); else exp_fp.push_back(e);
        last_g[m] = eg;

        // A continuously requesting source must be served within N cycles.
        if (m == 0) begin
            for (int i = 0; i < N; i++) begin
                if (reset || flush || !r[i]) begin
                    wait_cnt[i] = 0;
                end else if (g[i]) begin
                    check("fair_rr", 32'(wait_cnt[i] < N), 32'd1);
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                end
            end
        end
    endtask

    task automatic src_update(input int m);
        logic [N-1:0] r;
        r = (m == 0) ? req_rr : req_fp;
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] nd;
            logic [TW-1:0] nt;
            nd = DW'($urandom_range(0, 65535));
            nt = TW'($urandom_range(0, 7));
            if (last_g[m][i]) begin
                if (policy == 1 || (policy == 2 && $urandom_range(0, 1) == 0))
                    set_src(m, i, 1'b0, nd, nt);
                else
                    set_src(m, i, 1'b1, nd, nt);
            end else if (policy == 2 && !r[i] && $urandom_range(0, 2) == 0) begin
                set_src(m, i, 1'b1, nd, nt);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        eval_inst(0);
        eval_inst(1);
        @(posedge clock);
        #1;
        src_update(0);
        src_update(1);
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; policy = 1;
        req_rr = '0; req_fp = '0; data_rr = '0; data_fp = '0; tag_rr = '0; tag_fp = '0;
        for (int m = 0; m < 2; m++) begin
            mptr[m] = 0; mout[m] = '0; mtag[m] = '0; mid[m] = '0; last_g[m] = '0;
        end
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        repeat (2) cycle();
        reset = 1'b0;

        // Idle bus after reset
        repeat (5) cycle();

        // Single request, dropped once granted
        set_src(0, 2, 1'b1, 16'hBEEF, 3'd5);
        set_src(1, 2, 1'b1, 16'hBEEF, 3'd5);
        #1 check("t2_grant", 32'(grant_rr), 32'b0100);
        cycle();
        check("t2_out", 32'(out_rr), 32'hBEEF);
        check("t2_tag", 32'(rs_rr), 32'd5);
        check("t2_id", 32'(id_rr), 32'd2);
        check("t2_wcdb", 32'(wcdb_rr), 32'd1);
        cycle();
        check("t2_wcdb_off", 32'(wcdb_rr), 32'd0);
        check("t2_hold", 32'(out_rr), 32'hBEEF);

        // Round-robin rotation with all sources held
        reset_cycle();
        policy = 0;
        for (int i = 0; i < N; i++) set_src(0, i, 1'b1, DW'(16'h1000 + i), TW'(i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t3_id", 32'(id_rr), 32'(k % N));
            check("t3_wcdb", 32'(wcdb_rr), 32'd1);
        end

        // Fixed priority: source 1 starves source 3
        for (int i = 0; i < N; i++) set_src(1, i, i[0], DW'(16'h2000 + i), TW'(i));
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t4_grant", 32'(grant_fp), 32'b0010);
        end

        // Flush squashes one grant and leaves the pointer alone
        reset_cycle();
        for (int i = 0; i < N; i++) set_src(0, i, (i == 1 || i == 2), DW'(16'h3000 + i), TW'(i));
        for (int i = 0; i < N; i++) set_src(1, i, 1'b0, '0, '0);
        flush = 1'b1;
        cycle();
        check("t5_wcdb", 32'(wcdb_rr), 32'd0);
        flush = 1'b0;
        #1 check("t5_win", 32'(grant_rr), 32'b0010);
        cycle();

        // Reset mid-stream with rr_ptr at 2
        reset_cycle();
        for (int i = 0; i < N; i++) set_src(0, i, 1'b1, DW'(16'h4000 + i), TW'(i));
        repeat (2) cycle();
        reset = 1'b1;
        #1 check("t6_gnt_rst", 32'(grant_rr), 32'd0);
        cycle();
        check("t6_wcdb", 32'(wcdb_rr), 32'd0);
        reset = 1'b0;
        #1 check("t6_first", 32'(grant_rr), 32'b0001);
        cycle();

        // Random traffic on both instances
        policy = 2;
        reset_cycle();
        for (int k = 0; k < 300; k++) begin
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
